// File: rtl/ubtb_update_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ubtb_update_ctrl_pkg
// Purpose : Shared definitions for the micro-BTB update path.
//           - branch-type encodings (BRANCH_TYPE_*)
//           - VALID / INVALID flag values
//           - update-source encodings (UBTB_SRC_EX / UBTB_SRC_CM)
//           - queued update entry type (ubtb_upd_req_t)
// Revision: 1.0 - initial release
// ============================================================================
package ubtb_update_ctrl_pkg;

    localparam logic [1:0] BRANCH_TYPE_DIRECT   = 2'd0;
    localparam logic [1:0] BRANCH_TYPE_INDIRECT = 2'd1;
    localparam logic [1:0] BRANCH_TYPE_CALL     = 2'd2;
    localparam logic [1:0] BRANCH_TYPE_RET      = 2'd3;

    localparam logic VALID   = 1'b1;
    localparam logic INVALID = 1'b0;

    // Execute-stage training is speculative and can be squashed by a flush;
    // commit-stage training never is.
    localparam logic UBTB_SRC_EX = 1'b0;
    localparam logic UBTB_SRC_CM = 1'b1;

    typedef struct packed {
        logic        live;
        logic        src;
        logic [31:0] pc;
        logic [31:0] target;
        logic [1:0]  cut_pos;
        logic [1:0]  branch_type;
    } ubtb_upd_req_t;

endpackage
`default_nettype wire

// File: rtl/ubtb_update_ctrl_queue.sv
`default_nettype none
// ============================================================================
// Module  : ubtb_upd_queue
// Purpose : Ordered update queue. Holds storage, head/tail/count, flush kill
//           of execute-source entries and optional same-PC coalescing.
// Ports   : clk, rst_n          clock, async active-low reset
//           flush               kill queued execute-source entries
//           ex_push / ex_req    execute-source enqueue (already handshaken)
//           cm_push / cm_req    commit-source enqueue (already handshaken)
//           pop                 remove head this cycle
//           head_*              current head entry fields
//           count               occupied slots (live and dead)
// Macro   : UBTB_UPD_COALESCE_EN enables same-PC overwrite in place.
// Revision: 1.0 - initial release
// ============================================================================
module ubtb_upd_queue
    import ubtb_update_ctrl_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           ex_push,
    input  ubtb_upd_req_t                  ex_req,
    input  logic                           cm_push,
    input  ubtb_upd_req_t                  cm_req,
    input  logic                           pop,
    output logic                           head_live,
    output logic [31:0]                    head_pc,
    output logic [31:0]                    head_target,
    output logic [1:0]                     head_cut_pos,
    output logic [1:0]                     head_branch_type,
    output logic [$clog2(QUEUE_DEPTH):0]   count
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    ubtb_upd_req_t          r_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]       r_head;
    logic [PTR_W-1:0]       r_tail;
    logic [CNT_W-1:0]       r_count;

    logic                   w_ex_acc;
    logic                   w_ex_alloc;
    logic                   w_cm_alloc;
    logic                   w_cm_absorb;
    logic [QUEUE_DEPTH-1:0] w_ex_hit_vec;
    logic [QUEUE_DEPTH-1:0] w_cm_hit_vec;
    logic [PTR_W-1:0]       w_cm_slot;

    // An execute request handshaken during a flush is dropped outright.
    assign w_ex_acc = ex_push && !flush;

`ifdef UBTB_UPD_COALESCE_EN
    // Only entries that are still live after this edge are match candidates:
    // flush-killed execute entries and the head leaving this cycle are not.
    for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_match
        logic w_survive;
        assign w_survive = r_mem[gi].live
                        && !(flush && (r_mem[gi].src == UBTB_SRC_EX))
                        && !(pop && (PTR_W'(gi) == r_head));
        assign w_ex_hit_vec[gi] = w_ex_acc && w_survive && (r_mem[gi].pc == ex_req.pc);
        assign w_cm_hit_vec[gi] = cm_push && !w_cm_absorb && w_survive
                               && (r_mem[gi].pc == cm_req.pc);
    end
    // Same PC on both sources in one cycle: execute payload wins.
    assign w_cm_absorb = w_ex_acc && cm_push && (ex_req.pc == cm_req.pc);
`else
    assign w_ex_hit_vec = '0;
    assign w_cm_hit_vec = '0;
    assign w_cm_absorb  = 1'b0;
`endif

    assign w_ex_alloc = w_ex_acc && !(|w_ex_hit_vec);
    assign w_cm_alloc = cm_push && !(|w_cm_hit_vec) && !w_cm_absorb;
    // Execute is written first so it is older than a same-cycle commit.
    assign w_cm_slot  = r_tail + PTR_W'(w_ex_alloc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (flush && (r_mem[i].src == UBTB_SRC_EX)) begin
                    r_mem[i].live <= INVALID;
                end
                if (w_ex_hit_vec[i]) begin
                    r_mem[i].src         <= ex_req.src;
                    r_mem[i].target      <= ex_req.target;
                    r_mem[i].cut_pos     <= ex_req.cut_pos;
                    r_mem[i].branch_type <= ex_req.branch_type;
                end
                if (w_cm_hit_vec[i]) begin
                    r_mem[i].src         <= cm_req.src;
                    r_mem[i].target      <= cm_req.target;
                    r_mem[i].cut_pos     <= cm_req.cut_pos;
                    r_mem[i].branch_type <= cm_req.branch_type;
                end
            end
            // Clearing live on pop keeps vacated slots out of PC matching.
            if (pop) begin
                r_mem[r_head].live <= INVALID;
            end
            if (w_ex_alloc) begin
                r_mem[r_tail] <= ex_req;
            end
            if (w_cm_alloc) begin
                r_mem[w_cm_slot] <= cm_req;
            end
            r_head  <= r_head + PTR_W'(pop);
            r_tail  <= r_tail + PTR_W'(w_ex_alloc) + PTR_W'(w_cm_alloc);
            r_count <= r_count + CNT_W'(w_ex_alloc) + CNT_W'(w_cm_alloc) - CNT_W'(pop);
        end
    end

    assign head_live        = r_mem[r_head].live;
    assign head_pc          = r_mem[r_head].pc;
    assign head_target      = r_mem[r_head].target;
    assign head_cut_pos     = r_mem[r_head].cut_pos;
    assign head_branch_type = r_mem[r_head].branch_type;
    assign count            = r_count;

endmodule
`default_nettype wire

// File: rtl/ubtb_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ubtb_update_ctrl
// Purpose : Micro-BTB update scheduler. Accepts execute (speculative) and
//           commit training requests, queues them in order and drains at
//           most one per cycle onto the uBTB write port.
// Ports   : clk, rst_n                   clock, async active-low reset
//           ex_valid/ex_ready, ex_*      execute-source request
//           cm_valid/cm_ready, cm_*      commit-source request
//           flush                        squash queued execute entries
//           drain_en                     allow popping this cycle
//           update_valid, update_pc, target_pc, update_cut_pos,
//           update_branch_type           registered uBTB write
//           q_count                      occupied queue slots
// Macro   : UBTB_UPD_COALESCE_EN enables same-PC coalescing in the queue.
// Revision: 1.0 - initial release
// ============================================================================
module ubtb_update_ctrl
    import ubtb_update_ctrl_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ex_valid,
    output logic                          ex_ready,
    input  logic [31:0]                   ex_pc,
    input  logic [31:0]                   ex_target,
    input  logic [1:0]                    ex_cut_pos,
    input  logic [1:0]                    ex_branch_type,
    input  logic                          cm_valid,
    output logic                          cm_ready,
    input  logic [31:0]                   cm_pc,
    input  logic [31:0]                   cm_target,
    input  logic [1:0]                    cm_cut_pos,
    input  logic [1:0]                    cm_branch_type,
    input  logic                          flush,
    input  logic                          drain_en,
    output logic                          update_valid,
    output logic [31:0]                   update_pc,
    output logic [31:0]                   target_pc,
    output logic [1:0]                    update_cut_pos,
    output logic [1:0]                    update_branch_type,
    output logic [$clog2(QUEUE_DEPTH):0]  q_count
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

    logic [CNT_W-1:0] w_count;
    logic             w_ex_fire;
    logic             w_cm_fire;
    logic             w_pop;
    ubtb_upd_req_t    w_ex_req;
    ubtb_upd_req_t    w_cm_req;
    logic             w_head_live;
    logic [31:0]      w_head_pc;
    logic [31:0]      w_head_target;
    logic [1:0]       w_head_cut_pos;
    logic [1:0]       w_head_branch_type;

    logic             r_update_valid;
    logic [31:0]      r_update_pc;
    logic [31:0]      r_target_pc;
    logic [1:0]       r_update_cut_pos;
    logic [1:0]       r_update_branch_type;

    // Ready looks only at the registered count so a same-cycle pop never
    // creates a combinational path from drain_en to the ready outputs.
    // Commit stops one slot early, keeping the last slot for execute.
    assign ex_ready  = (w_count < CNT_W'(QUEUE_DEPTH));
    assign cm_ready  = (w_count < CNT_W'(QUEUE_DEPTH - 1));
    assign w_ex_fire = ex_valid && ex_ready;
    assign w_cm_fire = cm_valid && cm_ready;
    assign w_pop     = drain_en && (w_count != '0);

    assign w_ex_req = '{live: VALID, src: UBTB_SRC_EX, pc: ex_pc, target: ex_target,
                        cut_pos: ex_cut_pos, branch_type: ex_branch_type};
    assign w_cm_req = '{live: VALID, src: UBTB_SRC_CM, pc: cm_pc, target: cm_target,
                        cut_pos: cm_cut_pos, branch_type: cm_branch_type};

    ubtb_upd_queue #(
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush            (flush),
        .ex_push          (w_ex_fire),
        .ex_req           (w_ex_req),
        .cm_push          (w_cm_fire),
        .cm_req           (w_cm_req),
        .pop              (w_pop),
        .head_live        (w_head_live),
        .head_pc          (w_head_pc),
        .head_target      (w_head_target),
        .head_cut_pos     (w_head_cut_pos),
        .head_branch_type (w_head_branch_type),
        .count            (w_count)
    );

    // Head liveness is sampled before this edge's flush, so a live head
    // popped in the flush cycle still issues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_update_valid       <= 1'b0;
            r_update_pc          <= '0;
            r_target_pc          <= '0;
            r_update_cut_pos     <= '0;
            r_update_branch_type <= BRANCH_TYPE_DIRECT;
        end else begin
            r_update_valid <= w_pop && w_head_live;
            if (w_pop && w_head_live) begin
                r_update_pc          <= w_head_pc;
                r_target_pc          <= w_head_target;
                r_update_cut_pos     <= w_head_cut_pos;
                r_update_branch_type <= w_head_branch_type;
            end
        end
    end

    assign update_valid       = r_update_valid;
    assign update_pc          = r_update_pc;
    assign target_pc          = r_target_pc;
    assign update_cut_pos     = r_update_cut_pos;
    assign update_branch_type = r_update_branch_type;
    assign q_count            = w_count;

endmodule
`default_nettype wire

// File: tb/tb_ubtb_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_ubtb_update_ctrl
// Purpose : Self-checking bench for ubtb_update_ctrl. A queue-level reference
//           model predicts readiness, occupancy and the stream of uBTB
//           writes; a separate monitor compares the writes as they appear.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ubtb_update_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0, cm_valid = 1'b0, flush = 1'b0, drain_en = 1'b0;
    logic        ex_ready, cm_ready;
    logic [31:0] ex_pc = '0, ex_target = '0, cm_pc = '0, cm_target = '0;
    logic [1:0]  ex_cut_pos = '0, ex_branch_type = '0, cm_cut_pos = '0, cm_branch_type = '0;
    logic        update_valid;
    logic [31:0] update_pc, target_pc;
    logic [1:0]  update_cut_pos, update_branch_type;
    logic [$clog2(DEPTH):0] q_count;

    ubtb_update_ctrl #(.QUEUE_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_cut_pos(ex_cut_pos), .ex_branch_type(ex_branch_type),
        .cm_valid(cm_valid), .cm_ready(cm_ready), .cm_pc(cm_pc), .cm_target(cm_target),
        .cm_cut_pos(cm_cut_pos), .cm_branch_type(cm_branch_type),
        .flush(flush), .drain_en(drain_en),
        .update_valid(update_valid), .update_pc(update_pc), .target_pc(target_pc),
        .update_cut_pos(update_cut_pos), .update_branch_type(update_branch_type),
        .q_count(q_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        bit          live;
        bit          src;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic [1:0]  cut;
        logic [1:0]  bt;
    } ent_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic [1:0]  cut;
        logic [1:0]  bt;
        int          due;
    } exp_t;

    ent_t mq[$];
    exp_t sb[$];
    exp_t mon_e;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: actual %0h required %0h", nm, cyc, act, req);
        end
    endtask

    // Monitor: compares every uBTB write against the oldest expected one.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                while (sb.size() > 0 && sb[0].due < cyc) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL missing_update: actual none required pc=%0h at cycle %0d",
                             sb[0].pc, sb[0].due);
                    void'(sb.pop_front());
                end
                if (update_valid) begin
                    if (sb.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL spurious_update @cycle %0d: actual update_valid=1 pc=%0h required update_valid=0",
                                 cyc, update_pc);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("upd_pc", update_pc, mon_e.pc);
                        chk("upd_target", target_pc, mon_e.tgt);
                        chk("upd_cut_pos", update_cut_pos, mon_e.cut);
                        chk("upd_branch_type", update_branch_type, mon_e.bt);
                        chk("upd_cycle", cyc, mon_e.due);
                    end
                end
            end
        end
    end

    // One cycle of stimulus plus the reference model's view of that edge.
    // Called at posedge+1; returns at the next posedge+1.
    task automatic step(input bit exv, input logic [31:0] expc, input logic [31:0] ext,
                        input bit cmv, input logic [31:0] cmpc, input logic [31:0] cmt,
                        input bit fl, input bit dr);
        int cnt;
        bit exf, cmf, exacc, hit;
        ex_valid = exv; ex_pc = expc; ex_target = ext;
        ex_cut_pos = 2'($urandom); ex_branch_type = 2'($urandom);
        cm_valid = cmv; cm_pc = cmpc; cm_target = cmt;
        cm_cut_pos = 2'($urandom); cm_branch_type = 2'($urandom);
        flush = fl; drain_en = dr;
        cnt = mq.size();
        chk("q_count", q_count, cnt);
        chk("ex_ready", ex_ready, (cnt < DEPTH));
        chk("cm_ready", cm_ready, (cnt < DEPTH - 1));
        exf = exv && (cnt < DEPTH);
        cmf = cmv && (cnt < DEPTH - 1);
        if (dr && cnt > 0) begin
            if (mq[0].live)
                sb.push_back('{mq[0].pc, mq[0].tgt, mq[0].cut, mq[0].bt, cyc + 1});
            void'(mq.pop_front());
        end
        if (fl) foreach (mq[i]) if (mq[i].src == 1'b0) mq[i].live = 1'b0;
        exacc = exf && !fl;
        if (exacc) begin
            hit = 1'b0;
`ifdef UBTB_UPD_COALESCE_EN
            foreach (mq[i]) if (mq[i].live && mq[i].pc == ex_pc) begin
                mq[i].src = 1'b0; mq[i].tgt = ex_target;
                mq[i].cut = ex_cut_pos; mq[i].bt = ex_branch_type; hit = 1'b1;
            end
`endif
            if (!hit) mq.push_back('{1'b1, 1'b0, ex_pc, ex_target, ex_cut_pos, ex_branch_type});
        end
        if (cmf) begin
            hit = 1'b0;
`ifdef UBTB_UPD_COALESCE_EN
            if (exacc && cm_pc == ex_pc) hit = 1'b1;
            else foreach (mq[i]) if (mq[i].live && mq[i].pc == cm_pc) begin
                mq[i].src = 1'b1; mq[i].tgt = cm_target;
                mq[i].cut = cm_cut_pos; mq[i].bt = cm_branch_type; hit = 1'b1;
            end
`endif
            if (!hit) mq.push_back('{1'b1, 1'b1, cm_pc, cm_target, cm_cut_pos, cm_branch_type});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit dr, input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, dr);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_update_valid"}, update_valid, 1'b0);
        chk({tag, "_update_pc"}, update_pc, 32'h0);
        chk({tag, "_target_pc"}, target_pc, 32'h0);
        chk({tag, "_cut_pos"}, update_cut_pos, 2'd0);
        chk({tag, "_branch_type"}, update_branch_type, 2'd0);
        chk({tag, "_q_count"}, q_count, 0);
        chk({tag, "_ex_ready"}, ex_ready, 1'b1);
        chk({tag, "_cm_ready"}, cm_ready, 1'b1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Single execute request, two-cycle latency.
        step(1, 32'h1000, 32'h2000, 0, 0, 0, 0, 1);
        idle(1, 3);

        // Fill with drain off, readiness limits, then drain in order.
        for (int k = 0; k < 4; k++) step(1, 32'h100 + 32'(k * 16), 32'h900 + 32'(k), 0, 0, 0, 0, 0);
        step(1, 32'h555, 32'h666, 1, 32'h777, 32'h888, 0, 0);
        idle(0, 2);
        idle(1, 6);

        // Same-cycle execute and commit into an empty queue.
        step(1, 32'hA0, 32'hA1, 1, 32'hB0, 32'hB1, 0, 1);
        idle(1, 4);

        // Flush squashes execute entries only.
        step(1, 32'h10, 32'h11, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h20, 32'h21, 0, 0);
        step(1, 32'h30, 32'h31, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        idle(1, 5);

        // Same PC from commit then execute.
        step(0, 0, 0, 1, 32'h40, 32'h100, 0, 0);
        step(1, 32'h40, 32'h200, 0, 0, 0, 0, 0);
        idle(0, 1);
        idle(1, 4);

        // Reset with entries queued.
        for (int k = 0; k < 3; k++) step(1, 32'h300 + 32'(k * 16), 32'h400, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        mq.delete();
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1, 4);

        // Randomized traffic with a small PC pool to exercise matching.
        for (int k = 0; k < 500; k++) begin
            step(($urandom_range(0, 99) < 60), 32'($urandom_range(0, 5)) << 4, $urandom,
                 ($urandom_range(0, 99) < 50), 32'($urandom_range(0, 5)) << 4, $urandom,
                 ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 65));
        end
        idle(1, 8);
        chk("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
